// File: rtl/boot_image_requester_pkg.sv
// boot_image_requester_pkg: state encoding and dual-boot register map
package boot_image_requester_pkg;
  typedef enum logic [2:0] {IDLE, WR_SEL, RD_BUSY, GAP, WR_TRIG, DONE, ERR} state_t;
  localparam logic [2:0] ADDR_TRIG = 3'd0;
  localparam logic [2:0] ADDR_SEL = 3'd1;
  localparam logic [2:0] ADDR_BUSY = 3'd2;
  localparam int SEL_OVERWRITE = 0;
  localparam int SEL_IMAGE = 1;
  localparam logic [31:0] TRIG_RECONFIG = 32'h1;
  function automatic logic [31:0] sel_word(input logic img);
    sel_word = '0;
    sel_word[SEL_OVERWRITE] = 1'b1;
    sel_word[SEL_IMAGE] = img;
  endfunction
endpackage

// File: rtl/boot_image_requester_if.sv
// boot_image_requester_if: Avalon-MM link to the dual-boot IP
interface boot_image_requester_if;
  logic [2:0] avm_address;
  logic avm_read;
  logic avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic avm_waitrequest;
  modport master(output avm_address, avm_read, avm_write, avm_writedata, input avm_readdata, avm_waitrequest);
  modport slave(input avm_address, avm_read, avm_write, avm_writedata, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/boot_image_requester.sv
// boot_image_requester: selects a boot image, polls busy, then triggers reconfiguration
module boot_image_requester
  import boot_image_requester_pkg::*;
#(
  parameter int POLL_LIMIT = 1024,
  parameter int POLL_GAP = 15
) (
  input logic clk_clk,
  input logic reset_reset,
  input logic req_valid,
  input logic req_image,
  output logic req_ready,
  boot_image_requester_if.master avm,
  output logic stat_busy,
  output logic stat_done,
  output logic stat_error
);
  localparam logic [16:0] POLL_MAX = 17'(POLL_LIMIT);
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP > 0 ? POLL_GAP - 1 : 0);
  state_t state_q, state_d;
  logic img_q, img_d, err_q, err_d;
  logic [15:0] poll_q, poll_d;
  logic [7:0] gap_q, gap_d;
  // registers; reset wins over any pending bus stall
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= IDLE;
      img_q <= 1'b0;
      err_q <= 1'b0;
      poll_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      img_q <= img_d;
      err_q <= err_d;
      poll_q <= poll_d;
      gap_q <= gap_d;
    end
  end
  // next state, counters and bus/status outputs
  always_comb begin
    state_d = state_q;
    img_d = img_q;
    err_d = err_q;
    poll_d = poll_q;
    gap_d = gap_q;
    avm.avm_address = '0;
    avm.avm_read = 1'b0;
    avm.avm_write = 1'b0;
    avm.avm_writedata = '0;
    req_ready = state_q == IDLE;
    stat_busy = !(state_q inside {IDLE, DONE, ERR});
    stat_done = state_q == DONE;
    stat_error = err_q || state_q == ERR;
    case (state_q)
      IDLE: if (req_valid) begin
        img_d = req_image;
        poll_d = '0;
        err_d = 1'b0;
        state_d = WR_SEL;
      end
      WR_SEL: begin
        avm.avm_address = ADDR_SEL;
        avm.avm_write = 1'b1;
        avm.avm_writedata = sel_word(img_q);
        state_d = avm.avm_waitrequest ? WR_SEL : RD_BUSY;
      end
      RD_BUSY: begin
        avm.avm_address = ADDR_BUSY;
        avm.avm_read = 1'b1;
        if (!avm.avm_waitrequest) begin
          if (!avm.avm_readdata[0]) state_d = WR_TRIG;
          else if ({1'b0, poll_q} + 17'd1 < POLL_MAX) begin
            poll_d = poll_q == 16'hffff ? poll_q : poll_q + 16'd1;
            gap_d = '0;
            state_d = POLL_GAP == 0 ? RD_BUSY : GAP;
          end else state_d = ERR;
        end
      end
      GAP: begin
        gap_d = gap_q + 8'd1;
        state_d = gap_q == GAP_LAST ? RD_BUSY : GAP;
      end
      WR_TRIG: begin
        avm.avm_address = ADDR_TRIG;
        avm.avm_write = 1'b1;
        avm.avm_writedata = TRIG_RECONFIG;
        state_d = avm.avm_waitrequest ? WR_TRIG : DONE;
      end
      DONE: state_d = DONE;
      ERR: begin
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_boot_image_requester.sv
// tb_boot_image_requester: directed checks of the boot image requester
module tb_boot_image_requester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic va = 1'b0, vb = 1'b0, img = 1'b0, wreq = 1'b0;
  logic [31:0] rdata = '0;
  logic rdy_a, bsy_a, dn_a, er_a, rdy_b, bsy_b, dn_b, er_b;
  int vectors = 0, errs = 0;
  boot_image_requester_if ifa();
  boot_image_requester_if ifb();
  assign ifa.avm_waitrequest = wreq;
  assign ifa.avm_readdata = rdata;
  assign ifb.avm_waitrequest = wreq;
  assign ifb.avm_readdata = rdata;
  boot_image_requester #(.POLL_LIMIT(16), .POLL_GAP(2)) dut_a (
    .clk_clk(clk), .reset_reset(rst), .req_valid(va), .req_image(img), .req_ready(rdy_a),
    .avm(ifa.master), .stat_busy(bsy_a), .stat_done(dn_a), .stat_error(er_a));
  boot_image_requester #(.POLL_LIMIT(4), .POLL_GAP(0)) dut_b (
    .clk_clk(clk), .reset_reset(rst), .req_valid(vb), .req_image(img), .req_ready(rdy_b),
    .avm(ifb.master), .stat_busy(bsy_b), .stat_done(dn_b), .stat_error(er_b));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [36:0] bus(input bit sel);
    return sel ? {ifb.avm_read, ifb.avm_write, ifb.avm_address, ifb.avm_writedata}
               : {ifa.avm_read, ifa.avm_write, ifa.avm_address, ifa.avm_writedata};
  endfunction
  function automatic logic [3:0] stat(input bit sel);
    return sel ? {rdy_b, bsy_b, dn_b, er_b} : {rdy_a, bsy_a, dn_a, er_a};
  endfunction
  task automatic access(input bit sel, input string tag, input logic rd, input logic wr,
                        input logic [2:0] ad, input logic [31:0] wd, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      wreq = 1'b1;
      chk(tag, 64'(bus(sel)), 64'({rd, wr, ad, wd}));
      tick();
    end
    wreq = 1'b0;
    chk(tag, 64'(bus(sel)), 64'({rd, wr, ad, wd}));
    tick();
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("reset_stat_a", 64'(stat(0)), 64'(4'b1000));
    chk("reset_bus_a", 64'(bus(0)), 64'd0);
    chk("reset_stat_b", 64'(stat(1)), 64'(4'b1000));
    chk("reset_bus_b", 64'(bus(1)), 64'd0);
    // minimum-latency request for image1
    img = 1'b1;
    va = 1'b1;
    tick();
    va = 1'b0;
    chk("fast_busy", 64'(stat(0)), 64'(4'b0100));
    access(0, "fast_sel", 1'b0, 1'b1, 3'd1, 32'h3, 0);
    access(0, "fast_poll", 1'b1, 1'b0, 3'd2, 32'h0, 0);
    access(0, "fast_trig", 1'b0, 1'b1, 3'd0, 32'h1, 0);
    for (int i = 0; i < 3; i++) begin
      va = 1'b1;
      img = i[0];
      chk("done_stat", 64'(stat(0)), 64'(4'b0010));
      chk("done_bus", 64'(bus(0)), 64'd0);
      tick();
    end
    va = 1'b0;
    // image0 with three stall cycles on every access
    rst = 1'b1;
    tick();
    rst = 1'b0;
    img = 1'b0;
    va = 1'b1;
    tick();
    va = 1'b0;
    img = 1'b1;
    access(0, "stall_sel", 1'b0, 1'b1, 3'd1, 32'h1, 3);
    access(0, "stall_poll", 1'b1, 1'b0, 3'd2, 32'h0, 3);
    access(0, "stall_trig", 1'b0, 1'b1, 3'd0, 32'h1, 3);
    chk("stall_done", 64'(stat(0)), 64'(4'b0010));
    // five busy polls with a two-cycle gap, request spam throughout
    rst = 1'b1;
    tick();
    rst = 1'b0;
    img = 1'b1;
    va = 1'b1;
    tick();
    img = 1'b0;
    access(0, "gap_sel", 1'b0, 1'b1, 3'd1, 32'h3, 0);
    for (int p = 0; p < 6; p++) begin
      rdata = (p < 5) ? 32'h1 : 32'h0;
      access(0, "gap_poll", 1'b1, 1'b0, 3'd2, 32'h0, 0);
      if (p < 5) for (int g = 0; g < 2; g++) begin
        chk("gap_idle", 64'({stat(0), bus(0)}), 64'({4'b0100, 37'd0}));
        tick();
      end
    end
    access(0, "gap_trig", 1'b0, 1'b1, 3'd0, 32'h1, 0);
    chk("gap_done", 64'(stat(0)), 64'(4'b0010));
    va = 1'b0;
    // busy stuck high with POLL_LIMIT=4 on the second instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    img = 1'b0;
    vb = 1'b1;
    tick();
    vb = 1'b0;
    access(1, "to_sel", 1'b0, 1'b1, 3'd1, 32'h1, 0);
    rdata = 32'h1;
    for (int p = 0; p < 4; p++) access(1, "to_poll", 1'b1, 1'b0, 3'd2, 32'h0, 0);
    chk("to_err_stat", 64'(stat(1)), 64'(4'b0001));
    chk("to_err_bus", 64'(bus(1)), 64'd0);
    tick();
    chk("to_idle_stat", 64'(stat(1)), 64'(4'b1001));
    tick();
    chk("to_idle_hold", 64'({stat(1), bus(1)}), 64'({4'b1001, 37'd0}));
    vb = 1'b1;
    tick();
    vb = 1'b0;
    chk("to_reaccept", 64'(stat(1)), 64'(4'b0100));
    chk("to_reaccept_bus", 64'(bus(1)), 64'({1'b0, 1'b1, 3'd1, 32'h1}));
    // reset while the select write is stalled
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rdata = '0;
    img = 1'b0;
    va = 1'b1;
    tick();
    va = 1'b0;
    wreq = 1'b1;
    chk("rst_sel", 64'(bus(0)), 64'({1'b0, 1'b1, 3'd1, 32'h1}));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_bus", 64'(bus(0)), 64'd0);
    chk("rst_stat", 64'(stat(0)), 64'(4'b1000));
    img = 1'b1;
    va = 1'b1;
    tick();
    va = 1'b0;
    access(0, "rst_sel2", 1'b0, 1'b1, 3'd1, 32'h3, 0);
    access(0, "rst_poll2", 1'b1, 1'b0, 3'd2, 32'h0, 0);
    access(0, "rst_trig2", 1'b0, 1'b1, 3'd0, 32'h1, 0);
    chk("rst_done2", 64'(stat(0)), 64'(4'b0010));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/boot_image_requester.md
BOOT_IMAGE_REQUESTER -- requirements
Module: boot_image_requester

Interface
REQ-001 Parameter POLL_LIMIT, default 1024, max busy-register polls before timeout (range 1..65535).
REQ-002 Parameter POLL_GAP, default 15, idle clk_clk cycles between busy polls (range 0..255).
REQ-003 clk_clk  in  1  single system clock; all logic rising-edge.
REQ-004 reset_reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  reconfiguration request strobe.
REQ-006 req_image  in  1  target image: 0 = CFM0/image0, 1 = CFM1/image1.
REQ-007 req_ready  out  1  high when IDLE; request accepted on req_valid & req_ready.
REQ-008 avm_address  out  3  Avalon-MM word address to dual-boot IP.
REQ-009 avm_read  out  1  Avalon-MM read.
REQ-010 avm_write  out  1  Avalon-MM write.
REQ-011 avm_writedata  out  32  write data.
REQ-012 avm_readdata  in  32  read data, valid in the cycle avm_read is high and avm_waitrequest is low.
REQ-013 avm_waitrequest  in  1  slave stall.
REQ-014 stat_busy  out  1  high in every state except IDLE, DONE and ERR.
REQ-015 stat_done  out  1  trigger write accepted; device reconfiguration pending.
REQ-016 stat_error  out  1  busy-poll timeout occurred.

Function
REQ-017 FSM states: IDLE, WR_SEL, RD_BUSY, GAP, WR_TRIG, DONE, ERR.
REQ-018 IDLE: on req_valid & req_ready, latch req_image, clear poll counter, clear stat_error, go WR_SEL next cycle.
REQ-019 WR_SEL: avm_address=1, avm_write=1, avm_writedata={30'b0, img, 1'b1} (bit0 overwrite, bit1 config_sel); held stable until avm_waitrequest=0, then RD_BUSY.
REQ-020 RD_BUSY: avm_address=2, avm_read=1; held until avm_waitrequest=0; on that cycle sample avm_readdata[0].
REQ-021 Sampled busy=0 -> WR_TRIG; busy=1 and poll count+1 < POLL_LIMIT -> increment count, go GAP; busy=1 and count+1 = POLL_LIMIT -> ERR.
REQ-022 GAP: wait exactly POLL_GAP cycles (0 = straight back to RD_BUSY next cycle), then RD_BUSY.
REQ-023 WR_TRIG: avm_address=0, avm_write=1, avm_writedata=32'h1; held until avm_waitrequest=0, then DONE.
REQ-024 DONE: terminal; stat_done=1, req_ready=0, no bus activity until reset.
REQ-025 ERR: stat_error=1 for one cycle in ERR, then IDLE; stat_error stays high in IDLE until next accepted request.
REQ-026 avm_read and avm_write never high together; both low outside RD_BUSY/WR_SEL/WR_TRIG; avm_address/writedata = 0 when idle.
REQ-027 req_valid outside IDLE ignored (no queueing); req_image sampled only at acceptance.
REQ-028 Minimum latency request-accept to stat_done with zero waitrequest, busy=0: 4 cycles (WR_SEL, RD_BUSY, WR_TRIG, DONE).
REQ-029 Poll counter 16 bits, saturating; never wraps.

Reset
REQ-030 reset_reset=1 at a clock edge forces IDLE next cycle regardless of state or pending waitrequest; avm_read/avm_write/address/writedata=0, req_ready=1 after reset, stat_busy/stat_done/stat_error=0, counters 0, latched image 0.

Structure
REQ-031 Shared package holds state encoding and register constants: ADDR_TRIG=0, ADDR_SEL=1, ADDR_BUSY=2, SEL_OVERWRITE bit0, SEL_IMAGE bit1, TRIG_RECONFIG=32'h1.
REQ-032 Single module; no sub-module; gap and poll counters inline.

Verification
REQ-033 Reset, req_valid=1, req_image=1, waitrequest=0, busy=0 -> writes addr1=0x3, read addr2, write addr0=0x1; stat_done=1 on cycle 4.
REQ-034 req_image=0, waitrequest high 3 cycles on each access -> address/data/strobe stable through stalls; addr1 write data 0x1.
REQ-035 busy=1 for 5 polls then 0, POLL_GAP=2 -> 6 reads, 2 idle cycles between each, then trigger write.
REQ-036 POLL_LIMIT=4, busy stuck 1 -> exactly 4 reads, no trigger write, ERR, stat_error high, back to IDLE, req_ready=1.
REQ-037 reset_reset pulsed during WR_SEL with waitrequest=1 -> avm_write low next cycle, IDLE, all status 0; new request then completes normally.
REQ-038 req_valid pulsed repeatedly during RD_BUSY/GAP and in DONE -> no extra transactions; DONE holds with no bus activity.
